bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose: start  input  1  conversion request, sampled only in IDLE.
REQ-004 SHALL expose: bin  input  10  unsigned binary operand, 0..1023, sampled with start.
REQ-005 SHALL expose: ready  output  1  high only in IDLE.
REQ-006 SHALL expose: done_tick  output  1  one-cycle pulse, result valid.
REQ-007 SHALL expose: bcd3, bcd2, bcd1, bcd0  output  4 each  thousands, hundreds, tens, units digits; registered.
REQ-008 SHALL have one clock; reset is asynchronous and active-high.

Function
REQ-009 SHALL contain exactly one 4-bit add-3 adjust cell: input >=5 -> input+3, else unchanged. All four digits SHALL share it, one digit per cycle.
REQ-010 SHALL use states IDLE, ADJUST, SHIFT, DONE.
REQ-011 IDLE, start=1 at edge E0: load bin into a 10-bit shift reg; clear the 16-bit working BCD reg; set bit counter=10 and digit index=0; go to ADJUST.
REQ-012 IDLE, start=0: SHALL remain in IDLE with all registers unchanged.
REQ-013 ADJUST: each cycle SHALL pass working digit[index] through the shared cell and write it back, then increment index. After index 3, SHALL go to SHIFT.
REQ-014 SHIFT: SHALL shift {working BCD, shift reg} left by 1 as one 26-bit register, fill the LSB with 0, and decrement the counter. If the counter reaches 0, go to DONE; else go to ADJUST with index=0.
REQ-015 On the edge entering DONE, SHALL copy the working digits to bcd3..bcd0. The bcd outputs SHALL otherwise hold their value.
REQ-016 DONE SHALL last exactly 1 cycle with done_tick=1, then return to IDLE.
REQ-017 done_tick SHALL be 0 in all states other than DONE.
REQ-018 Latency: E0 accepts start; ADJUST/SHIFT occupy cycles 1..50 (10 x (4+1)); DONE is cycle 51 with done_tick=1 and bcd valid; IDLE is cycle 52.
REQ-019 start SHALL be ignored in ADJUST, SHIFT and DONE. A bin change during conversion SHALL NOT affect the result.
REQ-020 If start is held high continuously, a new conversion SHALL begin every 52 cycles.
REQ-021 Adjust SHALL occur before shift. No adjust SHALL follow the 10th shift.
REQ-022 Working digits SHALL never exceed 9 before adjust and never exceed 12 after adjust. An adjust-cell input >9 cannot occur; for such an input the cell SHALL output 0.

Reset
REQ-023 While reset=1: state=IDLE, shift reg=0, working BCD=0, counter=0, index=0, bcd3..bcd0=0, done_tick=0, ready=1.
REQ-024 Reset mid-conversion SHALL abort immediately and leave bcd outputs at 0. No done_tick SHALL follow.
REQ-025 The first start accepted is the first rising edge with reset=0 and start=1.

Verification
REQ-026 bin=0, start pulse at E0 -> done_tick at cycle 51 only; bcd=0,0,0,0; ready=0 for cycles 1..51, 1 at cycle 52.
REQ-027 bin=1023 -> bcd3..0=1,0,2,3. bin=999 -> 0,9,9,9. bin=5 -> 0,0,0,5. bin=10 -> 0,0,1,0.
REQ-028 start=1 during cycles 1..51 with bin=7 after accepting bin=512 -> result 0,5,1,2; no extra done_tick.
REQ-029 start held high with bin alternating 123/456 at each accept -> done_tick at cycles 51, 103, ...; results 0,1,2,3 then 0,4,5,6.
REQ-030 Prior result 0,0,4,2, start bin=300, reset asserted at cycle 20 -> outputs 0 immediately, ready=1, no done_tick. A fresh start of bin=300 after reset -> 0,3,0,0.
REQ-031 Exhaustive sweep bin=0..1023 -> every result SHALL equal the decimal digits of bin; every done_tick SHALL be exactly 51 cycles after its accept.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter
// One shared add-3 cell visits one digit per cycle; ten adjust/shift rounds per result.

module bin2bcd_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] bin,
    output logic       ready,
    output logic       done_tick,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_shift;
    logic [15:0] r_work;
    logic [3:0]  r_count;
    logic [1:0]  r_index;
    logic [15:0] r_bcd;

    logic [3:0]  w_digit_in;
    logic [3:0]  w_digit_adj;
    logic [15:0] w_work_adj;
    logic [25:0] w_shifted;
    logic        w_last_shift;

    // Digit mux feeding the single add-3 cell; out-of-range digits collapse to 0.
    always_comb begin
        w_digit_in = 4'd0;
        case (r_index)
            2'd0: w_digit_in = r_work[3:0];
            2'd1: w_digit_in = r_work[7:4];
            2'd2: w_digit_in = r_work[11:8];
            2'd3: w_digit_in = r_work[15:12];
            default: w_digit_in = 4'd0;
        endcase

        if (w_digit_in > 4'd9) begin
            w_digit_adj = 4'd0;
        end else if (w_digit_in >= 4'd5) begin
            w_digit_adj = w_digit_in + 4'd3;
        end else begin
            w_digit_adj = w_digit_in;
        end
    end

    always_comb begin
        w_work_adj = r_work;
        case (r_index)
            2'd0: w_work_adj[3:0]   = w_digit_adj;
            2'd1: w_work_adj[7:4]   = w_digit_adj;
            2'd2: w_work_adj[11:8]  = w_digit_adj;
            2'd3: w_work_adj[15:12] = w_digit_adj;
            default: w_work_adj = r_work;
        endcase
    end

    assign w_shifted    = {r_work[14:0], r_shift, 1'b0};
    assign w_last_shift = (r_count == 4'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = ADJUST;
                end
            end
            ADJUST: begin
                if (r_index == 2'd3) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_shift) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = ADJUST;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        done_tick = 1'b0;
        case (r_state)
            IDLE:    ready     = 1'b1;
            DONE:    done_tick = 1'b1;
            default: begin
                ready     = 1'b0;
                done_tick = 1'b0;
            end
        endcase
    end

    // Results are captured on the final shift so they are valid throughout DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= 10'd0;
            r_work  <= 16'd0;
            r_count <= 4'd0;
            r_index <= 2'd0;
            r_bcd   <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shift <= bin;
                        r_work  <= 16'd0;
                        r_count <= 4'd10;
                        r_index <= 2'd0;
                    end
                end
                ADJUST: begin
                    r_work  <= w_work_adj;
                    r_index <= r_index + 2'd1;
                end
                SHIFT: begin
                    r_work  <= w_shifted[25:10];
                    r_shift <= w_shifted[9:0];
                    r_count <= r_count - 4'd1;
                    r_index <= 2'd0;
                    if (w_last_shift) begin
                        r_bcd <= w_shifted[25:10];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bcd3 = r_bcd[15:12];
    assign bcd2 = r_bcd[11:8];
    assign bcd1 = r_bcd[7:4];
    assign bcd0 = r_bcd[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq
// A cycle model predicts ready/done_tick/bcd; accepted operands queue their expected digits.

module tb_bin2bcd_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [9:0] bin;
    logic       ready;
    logic       done_tick;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;

    int checks;
    int errors;

    logic [15:0] sb_q[$];
    int          m_phase;
    logic [15:0] m_out;

    bin2bcd_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Phase 0 is IDLE, 1..50 adjust/shift, 51 DONE.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_out   = 16'd0;
            sb_q.delete();
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    sb_q.push_back(to_bcd(int'(bin)));
                    m_phase = 1;
                end
            end else if (m_phase == 51) begin
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
                if (m_phase == 51) begin
                    if (sb_q.size() > 0) begin
                        m_out = sb_q.pop_front();
                    end else begin
                        check("sb_underflow", 1, 0);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("ready", int'(ready), int'(m_phase == 0));
        check("done_tick", int'(done_tick), int'(m_phase == 51));
        check("bcd", int'({bcd3, bcd2, bcd1, bcd0}), int'(m_out));
    end

    task automatic run(input int b);
        start = 1'b1;
        bin   = 10'(b);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 10'($urandom_range(0, 1023));
        repeat (52) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bin    = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run(0);
        run(1023);
        run(999);
        run(5);
        run(10);

        // start and bin wiggle throughout a conversion of 512
        start = 1'b1;
        bin   = 10'd512;
        @(posedge clk);
        #1;
        bin = 10'd7;
        repeat (50) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // held start: back-to-back 123 then 456
        start = 1'b1;
        bin   = 10'd123;
        @(posedge clk);
        #1;
        bin = 10'd456;
        repeat (52) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (52) @(posedge clk);
        #1;

        // reset aborts a conversion of 300 at cycle 20
        run(42);
        start = 1'b1;
        bin   = 10'd300;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_bcd", int'({bcd3, bcd2, bcd1, bcd0}), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done_tick), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        run(300);

        for (int i = 0; i < 1024; i++) begin
            run(i);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
